instr_prefetch: RTL



---
 rtl/ifetch_pkg.sv | 22 ++
 rtl/ifetch_fifo.sv | 50 +++++
 rtl/instr_prefetch.sv | 127 ++++++++++++
 3 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction prefetch stage.
// The misaligned-redirect fault path is enabled by defining PREFETCH_MISALIGN_EN.
package ifetch_pkg;

  localparam logic [31:0] INSTR_BYTES = 32'd4;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } fetchEntry_t;

  function automatic logic [31:0] alignPc(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

  function automatic logic [31:0] nextPc(input logic [31:0] addr);
    return addr + INSTR_BYTES;
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// DEPTH-entry synchronous FIFO of fetch entries with flush; flush with a
// simultaneous push leaves exactly the pushed entry in the FIFO.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     arstN,
  input  logic                     push,
  input  fetchEntry_t              pushEntry,
  input  logic                     pop,
  input  logic                     flush,
  output fetchEntry_t              headEntry,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetchEntry_t   mem [DEPTH];
  logic [PW-1:0] rdPtr;
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] wrIdx;

  assign wrIdx     = flush ? '0 : wrPtr;
  assign headEntry = mem[rdPtr];

  always_ff @(posedge clk or negedge arstN) begin
    if (!arstN) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else if (flush) begin
      rdPtr <= '0;
      wrPtr <= push ? PW'(1) : '0;
      count <= push ? CW'(1) : '0;
    end else begin
      rdPtr <= rdPtr + PW'(pop);
      wrPtr <= wrPtr + PW'(push);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage carries no reset; the top masks outputs while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wrIdx] <= pushEntry;
  end

endmodule

// File: rtl/instr_prefetch.sv
// Sequential instruction prefetcher: credit-limited req/gnt fetch, in-order
// responses buffered with PCs, redirect flush. Optional macro PREFETCH_MISALIGN_EN.
module instr_prefetch
  import ifetch_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_arst_n,
  output logic        o_memReq,
  output logic [31:0] o_memAddr,
  input  logic        i_memGnt,
  input  logic        i_memRvalid,
  input  logic [31:0] i_memRdata,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  input  logic        i_ready,
  input  logic        i_redirect,
  input  logic [31:0] i_redirectPc,
  output logic        o_fault
);

  localparam int          CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [31:0]   fetchPc;
  logic [31:0]   respPc;
  logic [31:0]   redirAligned;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [CW-1:0] fifoCount;
  logic [CW:0]   creditSum;
  logic          fetchEn;
  logic          reqFire;
  logic          rspAccept;
  logic          push;
  logic          pop;
  logic          misalign;
  logic          halted;
  fetchEntry_t   pushEntry;
  fetchEntry_t   headEntry;

`ifdef PREFETCH_MISALIGN_EN
  assign misalign = i_redirectPc[1:0] != 2'b00;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n)       halted <= 1'b0;
    else if (i_redirect) halted <= misalign;
  end
`else
  assign misalign = 1'b0;
  assign halted   = 1'b0;
`endif

  assign redirAligned = alignPc(i_redirectPc);

  // Outstanding requests plus buffered entries never exceed DEPTH, so every
  // response always has a FIFO slot waiting for it.
  assign creditSum = {1'b0, outstanding} + {1'b0, fifoCount};
  assign o_memReq  = fetchEn & ~i_redirect & ~halted & (creditSum < DEPTH_W);
  assign o_memAddr = fetchPc;
  assign reqFire   = o_memReq & i_memGnt;

  assign rspAccept = i_memRvalid & ~i_redirect & (discard == '0);
  assign pop       = o_valid & i_ready & ~i_redirect;
  assign push      = i_redirect ? misalign : rspAccept;

  always_comb begin
    pushEntry = '0;
    if (i_redirect) begin
      pushEntry.pc    = i_redirectPc;
      pushEntry.instr = 32'h0;
      pushEntry.fault = 1'b1;
    end else begin
      pushEntry.pc    = respPc;
      pushEntry.instr = i_memRdata;
      pushEntry.fault = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      fetchEn     <= 1'b0;
      fetchPc     <= RESET_PC;
      respPc      <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      fetchEn     <= 1'b1;
      outstanding <= outstanding + CW'(reqFire) - CW'(i_memRvalid);
      if (i_redirect) begin
        fetchPc <= redirAligned;
        respPc  <= redirAligned;
        // Everything still in flight belongs to the abandoned path.
        discard <= outstanding - CW'(i_memRvalid);
      end else begin
        if (reqFire)   fetchPc <= nextPc(fetchPc);
        if (rspAccept) respPc  <= nextPc(respPc);
        if (i_memRvalid && discard != '0) discard <= discard - CW'(1);
      end
    end
  end

  ifetch_fifo #(
    .DEPTH(DEPTH)
  ) uFifo (
    .clk      (i_clk),
    .arstN    (i_arst_n),
    .push     (push),
    .pushEntry(pushEntry),
    .pop      (pop),
    .flush    (i_redirect),
    .headEntry(headEntry),
    .count    (fifoCount)
  );

  assign o_valid = fifoCount != '0;
  assign o_instr = o_valid ? headEntry.instr : 32'h0;
  assign o_pc    = o_valid ? headEntry.pc    : 32'h0;
  assign o_fault = o_valid & headEntry.fault;

  rspNeedsRequest: assert property (@(posedge i_clk) disable iff (!i_arst_n)
    i_memRvalid |-> outstanding != '0);

endmodule
